// File: rtl/vend_dispense_if.sv
// vend_dispense_if: handshake and delivery signals between the vending FSM, the dispenser and the coin hopper
// master (FSM/hopper side): drives req_valid, bev_code, change_amt, coin_ready
// slave (dispenser side):   drives req_ready, bev_deliver, bev_id, coin_valid, coin_code, done, err, residual
interface vend_dispense_if #(parameter int AMT_W = 16);
  logic req_valid;
  logic req_ready;
  logic [1:0] bev_code;
  logic [AMT_W-1:0] change_amt;
  logic bev_deliver;
  logic [1:0] bev_id;
  logic coin_valid;
  logic coin_ready;
  logic [2:0] coin_code;
  logic done;
  logic err;
  logic [AMT_W-1:0] residual;
  modport master (
    output req_valid, bev_code, change_amt, coin_ready,
    input req_ready, bev_deliver, bev_id, coin_valid, coin_code, done, err, residual
  );
  modport slave (
    input req_valid, bev_code, change_amt, coin_ready,
    output req_ready, bev_deliver, bev_id, coin_valid, coin_code, done, err, residual
  );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: sequences beverage delivery then greedy coin change for one vend at a time
// clk, rst (synchronous, active-low); bus: vend request in, beverage pulse, coin token stream, done/err/residual out
module vend_dispense_ctrl #(
  parameter int BEV_DELAY = 10,
  parameter int CHG_DELAY = 20,
  parameter int AMT_W = 16
) (
  input logic clk,
  input logic rst,
  vend_dispense_if.slave bus
);
  localparam int MAXD = BEV_DELAY > CHG_DELAY ? BEV_DELAY : CHG_DELAY;
  localparam int CNT_W = $clog2(MAXD + 1);
  localparam logic [AMT_W-1:0] MIN_COIN = AMT_W'(5);
  typedef enum logic [2:0] {IDLE, BEV_WAIT, CHG_WAIT, CHG_OUT, FINISH} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [AMT_W-1:0] rem, rem_n;
  logic [1:0] code, code_n;
  logic bev_fire;
  function automatic logic [2:0] denom(input logic [AMT_W-1:0] a);
    return a >= AMT_W'(200) ? 3'd6 : a >= AMT_W'(100) ? 3'd5 : a >= AMT_W'(50) ? 3'd4 :
           a >= AMT_W'(20) ? 3'd3 : a >= AMT_W'(10) ? 3'd2 : a >= MIN_COIN ? 3'd1 : 3'd0;
  endfunction
  function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] c);
    return c == 3'd6 ? AMT_W'(200) : c == 3'd5 ? AMT_W'(100) : c == 3'd4 ? AMT_W'(50) :
           c == 3'd3 ? AMT_W'(20) : c == 3'd2 ? AMT_W'(10) : c == 3'd1 ? MIN_COIN : '0;
  endfunction
  // The BEV_WAIT counter runs BEV_DELAY-1 down to 0; the pulse occupies the cycle where it sits at 0.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rem_n = rem;
    code_n = code;
    case (state)
      IDLE: if (bus.req_valid) begin
        code_n = bus.bev_code;
        rem_n = bus.change_amt;
        state_n = bus.bev_code != 2'd0 ? BEV_WAIT : bus.change_amt >= MIN_COIN ? CHG_WAIT : FINISH;
        cnt_n = bus.bev_code != 2'd0 ? CNT_W'(BEV_DELAY - 1) : CNT_W'(CHG_DELAY - 1);
      end
      BEV_WAIT: begin
        cnt_n = cnt == '0 ? CNT_W'(CHG_DELAY - 1) : cnt - CNT_W'(1);
        if (cnt == '0) state_n = rem >= MIN_COIN ? CHG_WAIT : FINISH;
      end
      CHG_WAIT: begin
        cnt_n = cnt == '0 ? '0 : cnt - CNT_W'(1);
        if (cnt == '0) state_n = CHG_OUT;
      end
      CHG_OUT: if (bus.coin_ready) begin
        rem_n = rem - coin_value(bus.coin_code);
        if (rem_n < MIN_COIN) state_n = FINISH;
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    bev_fire = state_n == BEV_WAIT && cnt_n == '0;
  end
  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      code <= '0;
      bus.req_ready <= 1'b1;
      bus.bev_deliver <= 1'b0;
      bus.bev_id <= 2'd0;
      bus.coin_valid <= 1'b0;
      bus.coin_code <= 3'd0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      bus.residual <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rem <= rem_n;
      code <= code_n;
      bus.req_ready <= state_n == IDLE;
      bus.bev_deliver <= bev_fire;
      bus.bev_id <= bev_fire ? code_n : 2'd0;
      bus.coin_valid <= state_n == CHG_OUT;
      bus.coin_code <= state_n == CHG_OUT ? denom(rem_n) : 3'd0;
      bus.done <= state_n == FINISH;
      bus.err <= state_n == FINISH && rem_n != '0;
      bus.residual <= state_n == FINISH ? rem_n : '0;
    end
  end
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl: directed table-driven check of vend_dispense_ctrl with BEV_DELAY=10, CHG_DELAY=20
module tb_vend_dispense_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  vend_dispense_if #(.AMT_W(16)) bus();
  vend_dispense_ctrl #(.BEV_DELAY(10), .CHG_DELAY(20), .AMT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] bev;
    logic [15:0] amt;
    int stall_idx;
    int stall_len;
    bit poke;
    int bev_k;
    int first_k;
    int n;
    logic [23:0] codes;
    int done_k;
    logic err;
    logic [15:0] res;
  } vec_t;
  vec_t vecs[9];
  function automatic vec_t mk(input logic [1:0] bev, input logic [15:0] amt, input int si, input int sl,
                              input bit poke, input int bk, input int fk, input int n,
                              input logic [23:0] codes, input int dk, input logic err, input logic [15:0] res);
    vec_t v;
    v.bev = bev; v.amt = amt; v.stall_idx = si; v.stall_len = sl; v.poke = poke;
    v.bev_k = bk; v.first_k = fk; v.n = n; v.codes = codes; v.done_k = dk; v.err = err; v.res = res;
    return v;
  endfunction
  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // k counts edges after the acceptance edge t0; samples at negedge k show values after edge t0+k.
  task automatic run_vec(input int id, input vec_t v);
    int bev_k = -1, bev_n = 0, first_k = -1, done_k = -1, n = 0, stl = 0, viol = 0;
    logic [1:0] bid = 2'd0;
    logic [23:0] codes = '0;
    logic d_err = 1'b0;
    logic [15:0] d_res = '0;
    logic [2:0] held = 3'd0;
    check($sformatf("v%0d ready_before", id), bus.req_ready, 1);
    bus.bev_code = v.bev;
    bus.change_amt = v.amt;
    bus.req_valid = 1'b1;
    bus.coin_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 500 && done_k < 0; k++) begin
      @(negedge clk);
      bus.req_valid = v.poke && k >= 2 && k <= 4;
      bus.bev_code = bus.req_valid ? 2'd2 : 2'd0;
      bus.change_amt = bus.req_valid ? 16'd50 : 16'd0;
      if (v.poke && k >= 2 && k <= 4) check($sformatf("v%0d busy_ready k%0d", id, k), bus.req_ready, 0);
      if (bus.bev_deliver) begin
        bev_n++;
        bev_k = k;
        bid = bus.bev_id;
      end
      if (!bus.coin_valid && bus.coin_code != 3'd0) viol++;
      if (!bus.done && (bus.err || bus.residual != 16'd0)) viol++;
      if (bus.done) begin
        done_k = k;
        d_err = bus.err;
        d_res = bus.residual;
      end
      bus.coin_ready = 1'b1;
      if (bus.coin_valid) begin
        if (first_k < 0) first_k = k;
        if (n == v.stall_idx && stl > 0) check($sformatf("v%0d stall_hold k%0d", id, k), bus.coin_code, held);
        if (n == v.stall_idx && stl < v.stall_len) begin
          held = bus.coin_code;
          stl++;
          bus.coin_ready = 1'b0;
        end else begin
          if (n < 8) codes[3*n +: 3] = bus.coin_code;
          n++;
        end
      end
    end
    bus.req_valid = 1'b0;
    check($sformatf("v%0d bev_pulses", id), bev_n, v.bev != 2'd0);
    check($sformatf("v%0d bev_cycle", id), bev_k, v.bev_k);
    check($sformatf("v%0d bev_id", id), bid, v.bev);
    check($sformatf("v%0d first_coin", id), first_k, v.first_k);
    check($sformatf("v%0d coin_count", id), n, v.n);
    check($sformatf("v%0d coin_codes", id), codes, v.codes);
    check($sformatf("v%0d done_cycle", id), done_k, v.done_k);
    check($sformatf("v%0d err", id), d_err, v.err);
    check($sformatf("v%0d residual", id), d_res, v.res);
    check($sformatf("v%0d idle_violations", id), viol, 0);
    @(negedge clk);
    check($sformatf("v%0d ready_after", id), {bus.req_ready, bus.done}, 2'b10);
  endtask
  initial begin
    int act;
    vecs[0] = mk(2'd2, 16'd385, -1, 0, 1'b0, 9, 30, 6, {3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}, 36, 1'b0, 16'd0);
    vecs[1] = mk(2'd1, 16'd130, 1, 3, 1'b0, 9, 30, 3, {15'd0, 3'd2, 3'd3, 3'd5}, 36, 1'b0, 16'd0);
    vecs[2] = mk(2'd0, 16'd7, -1, 0, 1'b0, -1, 20, 1, {21'd0, 3'd1}, 21, 1'b1, 16'd2);
    vecs[3] = mk(2'd0, 16'd0, -1, 0, 1'b0, -1, -1, 0, 24'd0, 0, 1'b0, 16'd0);
    vecs[4] = mk(2'd1, 16'd0, -1, 0, 1'b1, 9, -1, 0, 24'd0, 10, 1'b0, 16'd0);
    vecs[5] = mk(2'd3, 16'd3, -1, 0, 1'b0, 9, -1, 0, 24'd0, 10, 1'b1, 16'd3);
    vecs[6] = mk(2'd0, 16'd4, -1, 0, 1'b0, -1, -1, 0, 24'd0, 0, 1'b1, 16'd4);
    vecs[7] = mk(2'd1, 16'd199, -1, 0, 1'b0, 9, 30, 5, {9'd0, 3'd1, 3'd3, 3'd3, 3'd4, 3'd5}, 35, 1'b1, 16'd4);
    vecs[8] = mk(2'd0, 16'hFFFF, -1, 0, 1'b0, -1, 20, 331, {8{3'd6}}, 351, 1'b0, 16'd0);
    bus.req_valid = 1'b0;
    bus.bev_code = 2'd2;
    bus.change_amt = 16'd100;
    bus.coin_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.req_valid = ~bus.req_valid;
      @(negedge clk);
      check($sformatf("reset ready c%0d", i), bus.req_ready, 1);
      check($sformatf("reset outs c%0d", i),
            {bus.bev_deliver, bus.bev_id, bus.coin_valid, bus.coin_code, bus.done, bus.err, bus.residual}, 0);
    end
    bus.req_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset ready", bus.req_ready, 1);
    check("post_reset outs", {bus.bev_deliver, bus.coin_valid, bus.done}, 0);
    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);
    bus.bev_code = 2'd0;
    bus.change_amt = 16'd370;
    bus.req_valid = 1'b1;
    bus.coin_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.change_amt = 16'd0;
    repeat (22) @(negedge clk);
    check("midreset third_coin_valid", bus.coin_valid, 1);
    check("midreset third_coin_code", bus.coin_code, 4);
    rst = 1'b0;
    @(negedge clk);
    check("midreset cleared",
          {bus.req_ready, bus.bev_deliver, bus.coin_valid, bus.coin_code, bus.done, bus.err, bus.residual},
          {1'b1, 23'd0});
    rst = 1'b1;
    act = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.bev_deliver || bus.coin_valid || bus.done || !bus.req_ready) act++;
    end
    check("midreset quiet", act, 0);
    run_vec(9, vecs[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
